// File: rtl/riscv_pkg.sv
// Shared RV32I core types: data width, register address width, zero register.
// Imported by the register file and its load scoreboard.
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Load-busy scoreboard: one bit per register, set by an issuing load and cleared by writeback; drives StallD.
// REGFILE_BYPASS_EN: a writeback to a busy register releases the stall in that same cycle.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_set_vld,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_wr_vld,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [AW-1:0] i_a1,
    input  logic [AW-1:0] i_a2,
    input  logic          i_use1,
    input  logic          i_use2,
    output logic          o_stall
);
    localparam int NREG = 2 ** AW;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_eff;
    logic            w_set;
    logic            w_clr;

    assign w_set = i_set_vld && (i_set_addr != AW'(REG_ZERO));
    assign w_clr = i_wr_vld && (i_wr_addr != AW'(REG_ZERO));

    // Set is applied after clear so a newer load on the same register keeps it busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (w_clr) r_busy[i_wr_addr]  <= 1'b0;
            if (w_set) r_busy[i_set_addr] <= 1'b1;
        end
    end

    always_comb begin
        w_busy_eff = r_busy;
`ifdef REGFILE_BYPASS_EN
        if (w_clr) w_busy_eff[i_wr_addr] = 1'b0;
`endif
    end

    assign o_stall = (i_use1 && (i_a1 != AW'(REG_ZERO)) && w_busy_eff[i_a1])
                  || (i_use2 && (i_a2 != AW'(REG_ZERO)) && w_busy_eff[i_a2]);
endmodule

// File: rtl/regfile_wb.sv
// RV32I register file fed by writeback: two combinational read ports, one write port, load-use stall.
// REGFILE_BYPASS_EN: same-cycle write-through on the read ports and early stall release.
module regfile_wb
    import riscv_pkg::*;
#(
    parameter int W  = XLEN,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] A1D,
    input  logic [AW-1:0] A2D,
    output logic [W-1:0]  RD1D,
    output logic [W-1:0]  RD2D,
    input  logic          Use1D,
    input  logic          Use2D,
    input  logic          LoadIssueE,
    input  logic [AW-1:0] RdE,
    input  logic          FlushE,
    input  logic          RegWriteW,
    input  logic [AW-1:0] RdW,
    input  logic [W-1:0]  ResultW,
    output logic          StallD
);
    localparam int NREG = 2 ** AW;

    logic [W-1:0] r_regs [NREG];
    logic         w_wr;

    assign w_wr = RegWriteW && (RdW != AW'(REG_ZERO));

    // x0 is reset with the rest and never written, so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[RdW] <= ResultW;
        end
    end

    always_comb begin
        RD1D = (A1D == AW'(REG_ZERO)) ? '0 : r_regs[A1D];
        RD2D = (A2D == AW'(REG_ZERO)) ? '0 : r_regs[A2D];
`ifdef REGFILE_BYPASS_EN
        if (w_wr && (RdW == A1D)) RD1D = ResultW;
        if (w_wr && (RdW == A2D)) RD2D = ResultW;
`endif
    end

    regfile_scoreboard #(.AW(AW)) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_set_vld (LoadIssueE && !FlushE),
        .i_set_addr(RdE),
        .i_wr_vld  (RegWriteW),
        .i_wr_addr (RdW),
        .i_a1      (A1D),
        .i_a2      (A2D),
        .i_use1    (Use1D),
        .i_use2    (Use2D),
        .o_stall   (StallD)
    );
endmodule

// File: tb/tb_regfile_wb.sv
// Directed and randomized checks of regfile_wb against an array/bit-vector reference model.
module tb_regfile_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  A1D, A2D, RdE, RdW;
    logic        Use1D, Use2D, LoadIssueE, FlushE, RegWriteW;
    logic [31:0] ResultW;
    logic [31:0] RD1D, RD2D;
    logic        StallD;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk(clk), .rst(rst), .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D),
        .Use1D(Use1D), .Use2D(Use2D), .LoadIssueE(LoadIssueE), .RdE(RdE),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallD(StallD)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && RegWriteW && RdW == a) return ResultW;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (BYP && RegWriteW && RdW == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_stall();
        return (Use1D && exp_busy(A1D)) || (Use2D && exp_busy(A2D));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rd1"}, RD1D, exp_rd(A1D));
        chk({tag, ".rd2"}, RD2D, exp_rd(A2D));
        chk({tag, ".stall"}, {31'h0, StallD}, {31'h0, exp_stall()});
    endtask

    // Advance one clock; the model commits using the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (RegWriteW && RdW != 0) begin
            m_reg[RdW]  = ResultW;
            m_busy[RdW] = 1'b0;
        end
        if (LoadIssueE && !FlushE && RdE != 0) m_busy[RdE] = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        A1D = 0; A2D = 0; Use1D = 0; Use2D = 0; LoadIssueE = 0; RdE = 0;
        FlushE = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #12;
        A1D = 5; A2D = 7; Use1D = 1; Use2D = 1;
        #1;
        chk("reset.rd1", RD1D, 32'h0);
        chk("reset.rd2", RD2D, 32'h0);
        chk("reset.stall", {31'h0, StallD}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Async reset mid-cycle wipes a fresh write and a pending load
        idle_inputs();
        RegWriteW = 1; RdW = 5; ResultW = 32'h1234; LoadIssueE = 1; RdE = 8;
        tick();
        idle_inputs();
        A1D = 5; A2D = 8; Use2D = 1;
        #1;
        chk("pre_rst.rd1", RD1D, 32'h1234);
        chk("pre_rst.stall", {31'h0, StallD}, 32'h1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.rd1", RD1D, 32'h0);
        chk("async_rst.stall", {31'h0, StallD}, 32'h0);
        #1 rst = 1'b0;
        tick();

        // x0 write dropped
        idle_inputs();
        RegWriteW = 1; RdW = 0; ResultW = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        #2;
        chk("x0.rd1", RD1D, 32'h0);

        // Write/read x7, same-cycle visibility depends on bypass
        RegWriteW = 1; RdW = 7; ResultW = 32'hDEAD_BEEF; A2D = 7;
        #2;
        chk("wr_same.rd2", RD2D, BYP ? 32'hDEAD_BEEF : 32'h0);
        tick();
        idle_inputs();
        A2D = 7;
        #2;
        chk("wr_next.rd2", RD2D, 32'hDEAD_BEEF);

        // Load-use on x9
        idle_inputs();
        LoadIssueE = 1; RdE = 9; A1D = 9; Use1D = 1;
        tick();
        LoadIssueE = 0; RdE = 0;
        #2;
        chk("lu.busy1", {31'h0, StallD}, 32'h1);
        tick();
        #2;
        chk("lu.busy2", {31'h0, StallD}, 32'h1);
        RegWriteW = 1; RdW = 9; ResultW = 32'hCAFE_0009;
        #2;
        chk("lu.wb_cycle", {31'h0, StallD}, BYP ? 32'h0 : 32'h1);
        tick();
        RegWriteW = 0; RdW = 0;
        #2;
        chk("lu.after", {31'h0, StallD}, 32'h0);
        chk("lu.data", RD1D, 32'hCAFE_0009);

        // Same-edge set and clear on x4: set wins
        idle_inputs();
        LoadIssueE = 1; RdE = 4; RegWriteW = 1; RdW = 4; ResultW = 32'h44;
        tick();
        idle_inputs();
        A2D = 4; Use2D = 1;
        #2;
        chk("prio.stall", {31'h0, StallD}, 32'h1);
        chk("prio.data", RD2D, 32'h44);

        // Flushed load does not mark; unused source does not stall
        idle_inputs();
        LoadIssueE = 1; FlushE = 1; RdE = 3;
        tick();
        idle_inputs();
        A1D = 3; Use1D = 1;
        #2;
        chk("flush.stall", {31'h0, StallD}, 32'h0);
        LoadIssueE = 1; RdE = 6;
        tick();
        idle_inputs();
        A1D = 6; Use1D = 0;
        #2;
        chk("nouse.stall", {31'h0, StallD}, 32'h0);
        Use1D = 1;
        #1;
        chk("use.stall", {31'h0, StallD}, 32'h1);
        tick();

        // Randomized traffic on a narrow address window so hazards recur
        for (int n = 0; n < 600; n++) begin
            A1D        = 5'($urandom_range(0, 7));
            A2D        = 5'($urandom_range(0, 7));
            Use1D      = 1'($urandom);
            Use2D      = 1'($urandom);
            LoadIssueE = ($urandom_range(0, 2) == 0);
            RdE        = 5'($urandom_range(0, 7));
            FlushE     = ($urandom_range(0, 4) == 0);
            RegWriteW  = 1'($urandom);
            RdW        = 5'($urandom_range(0, 7));
            ResultW    = $urandom;
            #2;
            check_model("rand");
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_model("rand_rst");
                rst = 1'b0;
                #1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
